// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: the head entry is always presented on q and
// rdreq acknowledges/pops it. Occupancy is tracked explicitly so full and empty are exact.
module sync_fifo #(
    parameter int width = 8,
    parameter int depth = 7,
    parameter int words = 128
) (
    input  logic               clock,
    input  logic               aclr,
    input  logic [width-1:0]   data,
    input  logic               wrreq,
    input  logic               rdreq,
    output logic [width-1:0]   q,
    output logic               empty,
    output logic               full,
    output logic [depth-1:0]   usedw
);

    localparam logic [depth:0]   cnt_full = (depth + 1)'(words);
    localparam logic [depth:0]   cnt_one  = (depth + 1)'(1);
    localparam logic [depth-1:0] ptr_one  = depth'(1);

    logic [width-1:0] mem [words];

    logic [depth-1:0] wp_reg, wp_next;
    logic [depth-1:0] rp_reg, rp_next;
    logic [depth:0]   cnt_reg, cnt_next;
    logic             wa, ra;

    assign wa = wrreq & ~full;
    assign ra = rdreq & ~empty;

    always_comb begin
        wp_next  = wp_reg;
        rp_next  = rp_reg;
        cnt_next = cnt_reg;
        if (wa) begin
            wp_next = wp_reg + ptr_one;
        end
        if (ra) begin
            rp_next = rp_reg + ptr_one;
        end
        // A simultaneous accepted write and read leaves occupancy unchanged.
        case ({wa, ra})
            2'b10:   cnt_next = cnt_reg + cnt_one;
            2'b01:   cnt_next = cnt_reg - cnt_one;
            default: cnt_next = cnt_reg;
        endcase
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            wp_reg  <= '0;
            rp_reg  <= '0;
            cnt_reg <= '0;
        end else begin
            wp_reg  <= wp_next;
            rp_reg  <= rp_next;
            cnt_reg <= cnt_next;
        end
    end

    // Storage is deliberately left out of the clear; stale words are never exposed
    // because the pointers and count restart from zero.
    always_ff @(posedge clock) begin
        if (wa) begin
            mem[wp_reg] <= data;
        end
    end

    assign q     = mem[rp_reg];
    assign empty = (cnt_reg == '0);
    assign full  = (cnt_reg == cnt_full);
    assign usedw = cnt_reg[depth-1:0];

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised and directed bench for sync_fifo: a queue-based reference model
// tracks the stored words, and a negedge monitor compares the DUT against it.
module tb_sync_fifo;

    localparam int W = 134;
    localparam int D = 7;
    localparam int N = 128;

    logic           clock;
    logic           aclr;
    logic [W-1:0]   data;
    logic           wrreq;
    logic           rdreq;
    logic [W-1:0]   q;
    logic           empty;
    logic           full;
    logic [D-1:0]   usedw;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 0;

    logic [W-1:0] model_q[$];

    sync_fifo #(.width(W), .depth(D), .words(N)) dut (
        .clock (clock),
        .aclr  (aclr),
        .data  (data),
        .wrreq (wrreq),
        .rdreq (rdreq),
        .q     (q),
        .empty (empty),
        .full  (full),
        .usedw (usedw)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue, accept rules taken from its own size.
    always @(posedge clock or posedge aclr) begin : model
        bit do_rd, do_wr;
        if (aclr) begin
            model_q.delete();
        end else begin
            do_rd = rdreq && (model_q.size() > 0);
            do_wr = wrreq && (model_q.size() < N);
            if (do_rd) void'(model_q.pop_front());
            if (do_wr) model_q.push_back(data);
        end
    end

    // Monitor: the head word and flags are compared against the model every cycle.
    always @(negedge clock) begin
        if (mon_en && !aclr) begin
            check("mon_empty", W'(empty), W'(model_q.size() == 0));
            check("mon_full",  W'(full),  W'(model_q.size() == N));
            check("mon_usedw", W'(usedw), W'(model_q.size() % N));
            if (model_q.size() > 0) check("mon_q", q, model_q[0]);
        end
    end

    task automatic step(input bit w, input bit r, input logic [W-1:0] d);
        wrreq = w;
        rdreq = r;
        data  = d;
        @(posedge clock);
        #1;
        wrreq = 0;
        rdreq = 0;
    endtask

    task automatic check_flags(input string name, input bit e, input bit f, input int u);
        check({name, "_empty"}, W'(empty), W'(e));
        check({name, "_full"},  W'(full),  W'(f));
        check({name, "_usedw"}, W'(usedw), W'(u));
    endtask

    task automatic mid_cycle_reset(input string name);
        #3;
        aclr = 1;
        #1;
        check_flags(name, 1, 0, 0);
        #2;
        aclr = 0;
        @(posedge clock);
        #1;
    endtask

    logic [W-1:0] word;
    logic [1:0]   tags [5] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10};

    initial begin
        aclr  = 1;
        wrreq = 0;
        rdreq = 0;
        data  = '0;
        repeat (2) @(posedge clock);
        #1;
        check_flags("reset", 1, 0, 0);
        aclr = 0;
        @(posedge clock);
        #1;
        mon_en = 1;

        // Reset mid-cycle while holding data; flags must clear before the next edge.
        for (int i = 0; i < 3; i++) step(1, 0, W'(40 + i));
        check_flags("pre_reset", 0, 0, 3);
        mid_cycle_reset("midreset");

        // Single word.
        step(1, 0, W'(12'hA5C));
        check_flags("single_wr", 0, 0, 1);
        check("single_q", q, W'(12'hA5C));
        step(0, 1, '0);
        check_flags("single_rd", 1, 0, 0);

        // Show-ahead burst with tags in the top bits.
        for (int i = 0; i < 5; i++) begin
            word = W'(1000 + i);
            word[W-1 -: 2] = tags[i];
            step(1, 0, word);
        end
        for (int i = 0; i < 5; i++) begin
            word = W'(1000 + i);
            word[W-1 -: 2] = tags[i];
            check("burst_q", q, word);
            wrreq = 0; rdreq = 1;
            @(posedge clock);
            #1;
        end
        rdreq = 0;
        check_flags("burst_end", 1, 0, 0);

        // Fill, overflow, drain.
        for (int i = 0; i < N; i++) step(1, 0, W'(i));
        check_flags("fill", 0, 1, 0);
        step(1, 0, W'(999));
        check_flags("overflow", 0, 1, 0);
        for (int i = 0; i < N; i++) begin
            check("drain_q", q, W'(i));
            step(0, 1, '0);
        end
        check_flags("drained", 1, 0, 0);

        // Simultaneous with 3 entries.
        for (int i = 0; i < 3; i++) step(1, 0, W'(10 + i));
        step(1, 1, W'(13));
        check_flags("both_mid", 0, 0, 3);
        check("both_mid_q", q, W'(11));
        for (int i = 0; i < 3; i++) step(0, 1, '0);

        // Simultaneous when full: the write is dropped.
        for (int i = 0; i < N; i++) step(1, 0, W'(200 + i));
        step(1, 1, W'(5555));
        check_flags("both_full", 0, 0, 127);
        for (int i = 1; i < N; i++) begin
            check("both_full_q", q, W'(200 + i));
            step(0, 1, '0);
        end
        check_flags("both_full_end", 1, 0, 0);

        // Simultaneous when empty: only the write lands.
        step(1, 1, W'(77));
        check_flags("both_empty", 0, 0, 1);
        check("both_empty_q", q, W'(77));
        step(0, 1, '0);

        // Wrap with about 2 entries held; the monitor checks ordering.
        step(1, 0, W'(1));
        step(1, 0, W'(2));
        for (int i = 0; i < 300; i++) begin
            bit w, r;
            w = (model_q.size() <= 1) ? 1'b1 : 1'($urandom_range(0, 1));
            r = (model_q.size() >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            step(w, r, {$urandom, $urandom, $urandom, $urandom, $urandom});
        end

        // Unconstrained random traffic, including underflow and overflow attempts.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 {$urandom, $urandom, $urandom, $urandom, $urandom});
        end
        while (model_q.size() > 0) step(0, 1, '0);

        // Reset while holding 10 entries, then a fresh write.
        for (int i = 0; i < 10; i++) step(1, 0, W'(300 + i));
        check_flags("pre_reset10", 0, 0, 10);
        mid_cycle_reset("reset10");
        step(1, 0, W'(7));
        check("after_reset_q", q, W'(7));
        check_flags("after_reset", 0, 0, 1);

        @(negedge clock);
        mon_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
